// File: rtl/dds_sweep_if.sv
// Key/bound inputs and frequency outputs of the DDS sweep controller.
// The master drives keys and sweep bounds. The slave is the controller.
interface dds_sweep_if #(
  parameter int FREQ_W = 20
);
  logic [3:0]        key_flag;
  logic [FREQ_W-1:0] sweep_lo;
  logic [FREQ_W-1:0] sweep_hi;
  logic [FREQ_W-1:0] freq;
  logic              freq_upd;
  logic [2:0]        step_idx;
  logic [1:0]        state;
  logic              sweep_wrap;

  modport master (
    output key_flag, sweep_lo, sweep_hi,
    input  freq, freq_upd, step_idx, state, sweep_wrap
  );

  modport slave (
    input  key_flag, sweep_lo, sweep_hi,
    output freq, freq_upd, step_idx, state, sweep_wrap
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency scheduler: manual up/down stepping with selectable step size,
// or a timed staircase sweep between live-clamped bounds that wraps to the low bound.
//
// state    | meaning
// MANUAL   | keys step freq up/down, saturating at F_MIN/F_MAX
// SW_IDLE  | sweep armed, freq parked at lo
// SW_RUN   | dwell timer running, freq steps toward hi then wraps to lo
// SW_PAUSE | sweep frozen, freq and dwell held
module dds_sweep_ctrl #(
  parameter int FREQ_W   = 20,
  parameter int F_MIN    = 1,
  parameter int F_MAX    = 999_999,
  parameter int DEF_FREQ = 1_000,
  parameter int DWELL    = 50_000
) (
  input logic        clk,
  input logic        rst,
  dds_sweep_if.slave bus
);
  typedef enum logic [1:0] {
    MANUAL   = 2'd0,
    SW_IDLE  = 2'd1,
    SW_RUN   = 2'd2,
    SW_PAUSE = 2'd3
  } state_t;

  localparam int DW = $clog2(DWELL);
  localparam logic [FREQ_W-1:0] FMIN = FREQ_W'(F_MIN);
  localparam logic [FREQ_W-1:0] FMAX = FREQ_W'(F_MAX);
  localparam logic [FREQ_W-1:0] FDEF = FREQ_W'(DEF_FREQ);
  localparam logic [DW-1:0]     DWELL_LAST = DW'(DWELL - 1);

  state_t            state_r, state_n;
  logic [FREQ_W-1:0] freq_r, freq_n;
  logic [DW-1:0]     dwell_r, dwell_n;
  logic [2:0]        step_r, step_n;
  logic              upd_r, wrap_r, wrap_n;

  logic [FREQ_W-1:0] lo, hi, inc_sat, dec_sat;
  logic [FREQ_W:0]   step, sum;
  logic              k0, k1, k2, k3;

  always_comb begin
    case (step_r)
      3'd0:    step = (FREQ_W+1)'(1);
      3'd1:    step = (FREQ_W+1)'(10);
      3'd2:    step = (FREQ_W+1)'(100);
      3'd3:    step = (FREQ_W+1)'(1_000);
      3'd4:    step = (FREQ_W+1)'(10_000);
      default: step = (FREQ_W+1)'(100_000);
    endcase
  end

  always_comb begin
    lo = (bus.sweep_lo < FMIN) ? FMIN : (bus.sweep_lo > FMAX) ? FMAX : bus.sweep_lo;
    hi = (bus.sweep_hi < FMIN) ? FMIN : (bus.sweep_hi > FMAX) ? FMAX : bus.sweep_hi;
    // one extra bit keeps freq+step and the underflow test free of wrap-around
    sum     = {1'b0, freq_r} + step;
    inc_sat = (sum > {1'b0, FMAX}) ? FMAX : sum[FREQ_W-1:0];
    dec_sat = ({1'b0, freq_r} < step + {1'b0, FMIN}) ? FMIN : freq_r - step[FREQ_W-1:0];
  end

  // priority [0] > [3] > [1] > [2]; lower keys in the same cycle are dropped
  always_comb begin
    k0 = bus.key_flag[0];
    k3 = bus.key_flag[3] & ~k0;
    k1 = bus.key_flag[1] & ~k0 & ~bus.key_flag[3];
    k2 = bus.key_flag[2] & ~k0 & ~bus.key_flag[3] & ~bus.key_flag[1];
  end

  always_comb begin
    state_n = state_r;
    freq_n  = freq_r;
    dwell_n = dwell_r;
    step_n  = step_r;
    wrap_n  = 1'b0;
    if (k3) step_n = (step_r == 3'd5) ? 3'd0 : step_r + 3'd1;
    case (state_r)
      MANUAL: begin
        if (k0) begin
          state_n = SW_IDLE;
          freq_n  = lo;
        end else if (k1) begin
          freq_n = inc_sat;
        end else if (k2) begin
          freq_n = dec_sat;
        end
      end
      SW_IDLE: begin
        if (k0) begin
          state_n = MANUAL;
        end else if (k1) begin
          state_n = SW_RUN;
          dwell_n = '0;
        end
      end
      SW_RUN: begin
        if (k0) begin
          state_n = MANUAL;
        end else if (k1) begin
          state_n = SW_PAUSE;
        end else if (k2) begin
          state_n = SW_IDLE;
          freq_n  = lo;
          dwell_n = '0;
        end else if (dwell_r == DWELL_LAST) begin
          dwell_n = '0;
          if (lo < hi && sum <= {1'b0, hi}) begin
            freq_n = sum[FREQ_W-1:0];
          end else begin
            freq_n = lo;
            wrap_n = 1'b1;
          end
        end else begin
          dwell_n = dwell_r + 1'b1;
        end
      end
      default: begin
        if (k0) begin
          state_n = MANUAL;
        end else if (k1) begin
          state_n = SW_RUN;
        end else if (k2) begin
          state_n = SW_IDLE;
          freq_n  = lo;
          dwell_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MANUAL;
      freq_r  <= FDEF;
      dwell_r <= '0;
      step_r  <= 3'd0;
      upd_r   <= 1'b0;
      wrap_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      freq_r  <= freq_n;
      dwell_r <= dwell_n;
      step_r  <= step_n;
      upd_r   <= (freq_n != freq_r);
      wrap_r  <= wrap_n;
    end
  end

  assign bus.freq       = freq_r;
  assign bus.freq_upd   = upd_r;
  assign bus.step_idx   = step_r;
  assign bus.state      = state_r;
  assign bus.sweep_wrap = wrap_r;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl with DWELL=4: expected freq/upd/wrap
// events are queued by the stimulus thread and popped by a negedge monitor.
module tb_dds_sweep_ctrl;
  typedef struct packed {
    logic [19:0] f;
    logic        u;
    logic        w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t e;

  dds_sweep_if #(.FREQ_W(20)) bus ();

  dds_sweep_ctrl #(.DWELL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input int f, input bit u, input bit w);
    exp_t x;
    x.f = 20'(f);
    x.u = u;
    x.w = w;
    exp_q.push_back(x);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_flag = k;
    @(negedge clk);
    bus.key_flag = 4'b0000;
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.freq_upd || bus.sweep_wrap)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_event: freq=%0d upd=%0b wrap=%0b, expected no event",
                 bus.freq, bus.freq_upd, bus.sweep_wrap);
      end else begin
        e = exp_q.pop_front();
        if (bus.freq != e.f || bus.freq_upd != e.u || bus.sweep_wrap != e.w) begin
          n_err++;
          $display("FAIL event: freq=%0d upd=%0b wrap=%0b, expected freq=%0d upd=%0b wrap=%0b",
                   bus.freq, bus.freq_upd, bus.sweep_wrap, e.f, e.u, e.w);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ef, nf;
    bus.key_flag = 4'b0000;
    bus.sweep_lo = 20'd100;
    bus.sweep_hi = 20'd130;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("reset_freq", int'(bus.freq), 1000);
    check("reset_state", int'(bus.state), 0);
    check("reset_step", int'(bus.step_idx), 0);
    check("reset_upd", int'(bus.freq_upd), 0);

    // manual mode, 100 kHz steps
    repeat (5) press(4'b1000);
    check("step_idx_5", int'(bus.step_idx), 5);
    push(101_000, 1'b1, 1'b0);
    press(4'b0010);
    check("manual_up", int'(bus.freq), 101_000);
    for (int i = 2; i <= 9; i++) begin
      push(i * 100_000 + 1_000, 1'b1, 1'b0);
      press(4'b0010);
    end
    push(999_999, 1'b1, 1'b0);
    press(4'b0010);
    press(4'b0010);
    check("manual_sat_hi", int'(bus.freq), 999_999);
    ef = 999_999;
    for (int i = 0; i < 20; i++) begin
      nf = (ef >= 100_001) ? ef - 100_000 : 1;
      if (nf != ef) push(nf, 1'b1, 1'b0);
      ef = nf;
      press(4'b0100);
    end
    check("manual_sat_lo", int'(bus.freq), 1);

    // sweep at 10 Hz steps
    press(4'b1000);
    press(4'b1000);
    check("step_idx_1", int'(bus.step_idx), 1);
    push(100, 1'b1, 1'b0);
    press(4'b0001);
    check("idle_state", int'(bus.state), 1);
    check("idle_freq", int'(bus.freq), 100);
    push(110, 1'b1, 1'b0);
    push(120, 1'b1, 1'b0);
    push(130, 1'b1, 1'b0);
    push(100, 1'b1, 1'b1);
    press(4'b0010);
    check("run_state", int'(bus.state), 2);
    repeat (3) @(negedge clk);
    check("run_before_first_step", int'(bus.freq), 100);
    @(negedge clk);
    check("run_first_step", int'(bus.freq), 110);
    repeat (12) @(negedge clk);
    check("wrap_freq", int'(bus.freq), 100);
    check("wrap_pulse", int'(bus.sweep_wrap), 1);
    @(negedge clk);
    check("wrap_one_cycle", int'(bus.sweep_wrap), 0);

    // pause with dwell=2, resume, abort
    press(4'b0010);
    check("pause_state", int'(bus.state), 3);
    repeat (20) @(negedge clk);
    check("pause_hold_freq", int'(bus.freq), 100);
    check("pause_hold_state", int'(bus.state), 3);
    push(110, 1'b1, 1'b0);
    press(4'b0010);
    check("resume_state", int'(bus.state), 2);
    @(negedge clk);
    check("resume_no_step_yet", int'(bus.freq), 100);
    @(negedge clk);
    check("resume_step", int'(bus.freq), 110);
    push(100, 1'b1, 1'b0);
    press(4'b0100);
    check("abort_state", int'(bus.state), 1);
    check("abort_freq", int'(bus.freq), 100);

    // simultaneous keys in MANUAL
    press(4'b0001);
    check("back_manual", int'(bus.state), 0);
    press(4'b0011);
    check("k0k1_state", int'(bus.state), 1);
    check("k0k1_freq", int'(bus.freq), 100);
    press(4'b0001);
    press(4'b1010);
    check("k3k1_step", int'(bus.step_idx), 2);
    check("k3k1_freq", int'(bus.freq), 100);
    check("k3k1_state", int'(bus.state), 0);

    // degenerate bounds, then reset mid-run
    bus.sweep_lo = 20'd200;
    bus.sweep_hi = 20'd150;
    push(200, 1'b1, 1'b0);
    press(4'b0001);
    repeat (3) push(200, 1'b0, 1'b1);
    press(4'b0010);
    check("degen_state", int'(bus.state), 2);
    repeat (12) @(negedge clk);
    check("degen_freq", int'(bus.freq), 200);
    check("degen_wrap", int'(bus.sweep_wrap), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_freq", int'(bus.freq), 1000);
    check("rst_state", int'(bus.state), 0);
    check("rst_step", int'(bus.step_idx), 0);
    check("rst_upd", int'(bus.freq_upd), 0);
    check("rst_wrap", int'(bus.sweep_wrap), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency scheduler for the DDS datapath: turns debounced key pulses into the frequency word driven to the DDS core and the display. It supports a manual mode (step up/down with selectable step size) and an automatic sweep mode (timed staircase from a low to a high bound, then wrap). It sits between the key-edge block and the DDS/display blocks, replacing direct key-to-frequency control.

## Interface
- FREQ_W, 20, width of the frequency word (Hz).
- F_MIN, 1, lowest legal frequency.
- F_MAX, 999_999, highest legal frequency (6-digit display limit).
- DEF_FREQ, 1_000, frequency after reset.
- DWELL, 50_000, clk cycles per sweep step (≥2).

- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_flag  in  4  one-cycle key pulses: [0] mode, [1] up/run, [2] down/abort, [3] step select.
- sweep_lo  in  FREQ_W  sweep start frequency, used live.
- sweep_hi  in  FREQ_W  sweep end frequency, used live.
- freq  out  FREQ_W  frequency word to the DDS core and display, registered.
- freq_upd  out  1  one-cycle pulse in the cycle `freq` takes a new value.
- step_idx  out  3  step index 0..5 → step = 1, 10, 100, 1k, 10k, 100k Hz.
- state  out  2  0 MANUAL, 1 SW_IDLE, 2 SW_RUN, 3 SW_PAUSE.
- sweep_wrap  out  1  one-cycle pulse when the sweep returns to sweep_lo.

## Operation
- Reset values: freq=DEF_FREQ, state=MANUAL, step_idx=0, freq_upd=0, sweep_wrap=0, dwell counter=0.
- Effective bounds:
  - lo = clamp(sweep_lo, F_MIN, F_MAX).
  - hi = clamp(sweep_hi, F_MIN, F_MAX).
- Key priority: when several key_flag bits are high in one cycle, only the highest is serviced: [0] > [3] > [1] > [2]. The others are dropped.
- key_flag[3], any state: step_idx increments, 5 wraps to 0. Takes effect on the next increment or decrement. The dwell counter is not disturbed.
- MANUAL:
  - k1: freq = min(freq+step, F_MAX).
  - k2: freq = max(freq−step, F_MIN).
  - Arithmetic is FREQ_W+1 bits so no wrap-around occurs.
  - k0: go to SW_IDLE and set freq=lo.
- SW_IDLE:
  - freq holds.
  - k1: go to SW_RUN with dwell=0.
  - k2: ignored.
  - k0: go to MANUAL.
- SW_RUN:
  - dwell counts 0..DWELL−1.
  - At DWELL−1: dwell=0, and
    - if freq+step ≤ hi: freq += step;
    - else: freq=lo and pulse sweep_wrap.
  - k1: go to SW_PAUSE; dwell holds its value.
  - k2: go to SW_IDLE with freq=lo and dwell=0.
  - k0: go to MANUAL with freq retained.
- SW_PAUSE:
  - freq and dwell hold.
  - k1: go to SW_RUN and resume counting from the held dwell.
  - k2: go to SW_IDLE with freq=lo and dwell=0.
  - k0: go to MANUAL.
- Degenerate sweep (lo ≥ hi): every dwell expiry sets freq=lo and pulses sweep_wrap.
- If freq lies outside [lo, hi] in SW_RUN (bounds changed live): the next expiry with freq+step > hi wraps to lo. Otherwise stepping continues from the current freq.
- Any key that causes a transition also suppresses the dwell expiry in the same cycle. The key action wins.
- freq_upd pulses only if the new freq differs from the old one. A saturated step, or lo equal to the current freq, gives no pulse.

## Timing
- Key-to-output latency: freq, state and step_idx change on the clock edge that samples the key pulse, i.e. one cycle after the pulse is asserted.
- freq_upd and sweep_wrap are registered and coincide with the freq change.
- Sweep period: one freq step every DWELL cycles. The first step occurs DWELL cycles after entering SW_RUN.
- rst asserted mid-sweep: all outputs return to reset values on the next edge. No pending pulse survives.

## Test plan
Bench parameters: DWELL=4, sweep_lo=100, sweep_hi=130.
- Reset, then idle 10 cycles → freq=1000, state=0, step_idx=0, no freq_upd.
- Manual, step_idx=5:
  - k1 from 1000 → 101_000.
  - Repeated k1 → saturates at 999_999. The final saturating press gives no freq_upd.
  - k2 ×20 → 1 (F_MIN).
- Sweep, step_idx=1 (10 Hz):
  - k0 → state=1, freq=100.
  - k1 → state=2.
  - freq steps 110, 120, 130 at 4-cycle intervals, then 100 with sweep_wrap one cycle long.
- Pause/abort:
  - k1 at dwell=2 → state=3 and freq holds for 20 cycles.
  - k1 again → next step 2 cycles later.
  - k2 → state=1, freq=100.
- Simultaneous k0+k1 in MANUAL → only the mode change (state=1). k3+k1 in MANUAL → only step_idx advances, freq unchanged.
- Degenerate bounds (sweep_lo=200, sweep_hi=150) in SW_RUN → freq stays 200 and sweep_wrap pulses every 4 cycles. rst asserted mid-run → freq=1000, state=0 on the next edge.
